frame_buffer_mc: RTL and testbench

Multi-channel framed transaction buffer. It is the parametrised successor of the single-buffer start/stop capture-and-replay device.
- Accepts word frames delimited by start/stop on any of CH channels and stores only complete frames.
- Replays one whole frame per read request with start/stop framing on the output.
- Sits between the bus-side system interface and the device's consumer logic.
- Single clock edge throughout (posedge).

---
 rtl/frame_buffer_pkg.sv | 28 ++
 rtl/frame_buffer_if.sv | 37 +++
 rtl/frame_len_fifo.sv | 56 +++++
 rtl/frame_buffer_mc.sv | 242 ++++++++++++++++++++++++
 tb/tb_frame_buffer_mc.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/frame_buffer_pkg.sv
// Shared types for the multi-channel framed transaction buffer.
package frame_buffer_pkg;

  // Pointer/length counters are kept wide and wrap modulo 2^PTR_W; the low
  // $clog2(DEPTH) bits address storage, so any power-of-2 DEPTH up to 2^15 works.
  localparam int unsigned PTR_W = 16;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W-1:0] len_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } rd_state_t;

  // Per-channel write bookkeeping: open frame flag, next write slot, end of committed data.
  typedef struct packed {
    logic open;
    ptr_t wr;
    ptr_t commit;
  } wr_state_t;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/frame_buffer_if.sv
// Bus-side write/replay interface of the frame buffer.
interface frame_buffer_if
  import frame_buffer_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned CH = 2
);
  localparam int unsigned CW = clog2_min1(CH);

  logic          in_valid;
  logic [CW-1:0] in_ch;
  logic          in_start;
  logic          in_stop;
  logic [N-1:0]  in_data;
  logic          rd_req;
  logic [CW-1:0] rd_ch;
  logic          out_valid;
  logic          out_start;
  logic          out_stop;
  logic [CW-1:0] out_ch;
  logic [N-1:0]  out_data;
  logic          busy;
  logic [CH-1:0] empty;
  logic [CH-1:0] full;
  logic          drop;
  logic          rd_nack;

  modport master (
    output in_valid, in_ch, in_start, in_stop, in_data, rd_req, rd_ch,
    input  out_valid, out_start, out_stop, out_ch, out_data, busy, empty, full, drop, rd_nack
  );

  modport slave (
    input  in_valid, in_ch, in_start, in_stop, in_data, rd_req, rd_ch,
    output out_valid, out_start, out_stop, out_ch, out_data, busy, empty, full, drop, rd_nack
  );
endinterface

// File: rtl/frame_len_fifo.sv
// Queue of committed frame lengths for one channel.
module frame_len_fifo
  import frame_buffer_pkg::*;
#(
  parameter int unsigned W      = 11,
  parameter int unsigned FRAMES = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data_c,
  output logic         full,
  output logic         empty
);
  localparam int unsigned AW   = clog2_min1(FRAMES);
  localparam int unsigned CNTW = $clog2(FRAMES + 1);

  logic [W-1:0]    mem [FRAMES];
  logic [AW-1:0]   wptr, rptr;
  logic [CNTW-1:0] count, count_d;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(FRAMES - 1)) ? '0 : p + AW'(1);
  endfunction

  assign pop_data_c = mem[rptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count + CNTW'(push) - CNTW'(pop);
  end

  // Length storage.
  always_ff @(posedge clock) begin
    if (push) mem[wptr] <= push_data;
  end

  // Pointers, count and registered status flags.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push) wptr <= bump(wptr);
      if (pop)  rptr <= bump(rptr);
      count <= count_d;
      full  <= (count_d == CNTW'(FRAMES));
      empty <= (count_d == '0);
    end
  end
endmodule

// File: rtl/frame_buffer_mc.sv
// Multi-channel frame buffer: stores complete start/stop frames, replays one per request.
module frame_buffer_mc
  import frame_buffer_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned CH     = 2,
  parameter int unsigned FRAMES = 16
) (
  input logic           clock,
  input logic           reset_n,
  frame_buffer_if.slave bus
);
  localparam int unsigned CW = clog2_min1(CH);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned AW = clog2_min1(CH * DEPTH);

  logic [N-1:0]  mem [CH*DEPTH];
  wr_state_t     wst_q [CH];
  wr_state_t     wst_d [CH];
  ptr_t          rd_ptr_q [CH];
  ptr_t          rd_ptr_d [CH];
  logic [LW-1:0] head_len [CH];
  logic [CH-1:0] push, pop, lf_full, lf_empty;
  logic [LW-1:0] push_len;

  logic [CW-1:0] wch;
  wr_state_t     wcur, wnxt;
  logic          base_full, open_full;
  len_t          flen;
  logic          mem_we, rd_en;
  logic [AW-1:0] mem_waddr, mem_raddr;

  rd_state_t     state_q, state_d;
  logic [CW-1:0] sel_q, sel_d;
  logic [LW-1:0] remain_q, remain_d;

  logic          out_valid_d, out_start_d, out_stop_d, busy_d, drop_d, nack_d;
  logic [CW-1:0] out_ch_d;
  logic [CH-1:0] full_d;

  logic          out_valid_q, out_start_q, out_stop_q, busy_q, drop_q, nack_q;
  logic [CW-1:0] out_ch_q;
  logic [N-1:0]  out_data_q;
  logic [CH-1:0] full_q;

  function automatic logic [AW-1:0] addr(input logic [CW-1:0] c, input ptr_t p);
    return AW'({c, p[PW-1:0]});
  endfunction

  for (genvar c = 0; c < CH; c++) begin : g_len
    frame_len_fifo #(.W(LW), .FRAMES(FRAMES)) u_len (
      .clock      (clock),
      .reset_n    (reset_n),
      .push       (push[c]),
      .push_data  (push_len),
      .pop        (pop[c]),
      .pop_data_c (head_len[c]),
      .full       (lf_full[c]),
      .empty      (lf_empty[c])
    );
  end

  assign wch = bus.in_ch;

  // Write side: open/extend/commit/discard frames on the addressed channel.
  always_comb begin
    wst_d     = wst_q;
    push      = '0;
    push_len  = '0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    drop_d    = 1'b0;
    flen      = '0;
    wcur      = wst_q[wch];
    wnxt      = wcur;
    base_full = ((wcur.commit - rd_ptr_q[wch]) == PTR_W'(DEPTH));
    open_full = ((wcur.wr - rd_ptr_q[wch]) == PTR_W'(DEPTH));
    if (bus.in_valid) begin
      if (bus.in_start) begin
        // A new start always abandons whatever frame was open.
        wnxt.open = 1'b0;
        wnxt.wr   = wcur.commit;
        if (wcur.open || lf_full[wch] || base_full) drop_d = 1'b1;
        if (!lf_full[wch] && !base_full) begin
          mem_we    = 1'b1;
          mem_waddr = addr(wch, wcur.commit);
          wnxt.wr   = wcur.commit + PTR_W'(1);
          if (bus.in_stop) begin
            wnxt.commit = wnxt.wr;
            push[wch]   = 1'b1;
            push_len    = LW'(1);
          end else begin
            wnxt.open = 1'b1;
          end
        end
      end else if (wcur.open) begin
        if (open_full) begin
          // Storage exhausted mid-frame: roll the whole frame back.
          wnxt.open = 1'b0;
          wnxt.wr   = wcur.commit;
          drop_d    = 1'b1;
        end else begin
          mem_we    = 1'b1;
          mem_waddr = addr(wch, wcur.wr);
          wnxt.wr   = wcur.wr + PTR_W'(1);
          if (bus.in_stop) begin
            flen        = wnxt.wr - wcur.commit;
            wnxt.commit = wnxt.wr;
            wnxt.open   = 1'b0;
            push[wch]   = 1'b1;
            push_len    = LW'(flen);
          end
        end
      end
    end
    wst_d[wch] = wnxt;
  end

  // Replay FSM next state and next registered outputs.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    remain_d    = remain_q;
    rd_ptr_d    = rd_ptr_q;
    pop         = '0;
    rd_en       = 1'b0;
    mem_raddr   = '0;
    out_valid_d = 1'b0;
    out_start_d = 1'b0;
    out_stop_d  = 1'b0;
    nack_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.rd_req) begin
          if (lf_empty[bus.rd_ch]) begin
            nack_d = 1'b1;
          end else begin
            pop[bus.rd_ch]      = 1'b1;
            sel_d               = bus.rd_ch;
            rd_en               = 1'b1;
            mem_raddr           = addr(bus.rd_ch, rd_ptr_q[bus.rd_ch]);
            rd_ptr_d[bus.rd_ch] = rd_ptr_q[bus.rd_ch] + PTR_W'(1);
            remain_d            = head_len[bus.rd_ch] - LW'(1);
            out_valid_d         = 1'b1;
            out_start_d         = 1'b1;
            out_stop_d          = (head_len[bus.rd_ch] == LW'(1));
            state_d             = SEND;
          end
        end
      end
      SEND: begin
        if (bus.rd_req) nack_d = 1'b1;
        if (remain_q != '0) begin
          rd_en           = 1'b1;
          mem_raddr       = addr(sel_q, rd_ptr_q[sel_q]);
          rd_ptr_d[sel_q] = rd_ptr_q[sel_q] + PTR_W'(1);
          remain_d        = remain_q - LW'(1);
          out_valid_d     = 1'b1;
          out_stop_d      = (remain_q == LW'(1));
        end else begin
          state_d = IDLE;
        end
      end
    endcase
    busy_d   = (state_d == SEND);
    out_ch_d = out_valid_d ? sel_d : '0;
  end

  // Per-channel storage-full flag, counting committed plus open words.
  always_comb begin
    full_d = '0;
    for (int c = 0; c < CH; c++) begin
      full_d[c] = ((wst_d[c].wr - rd_ptr_d[c]) == PTR_W'(DEPTH));
    end
  end

  // Replay FSM state register.
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Channel pointers and replay bookkeeping.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int c = 0; c < CH; c++) begin
        wst_q[c]    <= '0;
        rd_ptr_q[c] <= '0;
      end
      sel_q    <= '0;
      remain_q <= '0;
    end else begin
      wst_q    <= wst_d;
      rd_ptr_q <= rd_ptr_d;
      sel_q    <= sel_d;
      remain_q <= remain_d;
    end
  end

  // Frame storage write port.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= bus.in_data;
  end

  // Registered outputs; read data is zero outside a replay word.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      out_stop_q  <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      full_q      <= '0;
      drop_q      <= 1'b0;
      nack_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_start_q <= out_start_d;
      out_stop_q  <= out_stop_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= rd_en ? mem[mem_raddr] : '0;
      busy_q      <= busy_d;
      full_q      <= full_d;
      drop_q      <= drop_d;
      nack_q      <= nack_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_start = out_start_q;
  assign bus.out_stop  = out_stop_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;
  assign bus.empty     = lf_empty;
  assign bus.full      = full_q;
  assign bus.drop      = drop_q;
  assign bus.rd_nack   = nack_q;
endmodule

// File: tb/tb_frame_buffer_mc.sv
// Directed bench for frame_buffer_mc (2 channels, 8 words/channel, 4 frames/channel).
module tb_frame_buffer_mc;
  import frame_buffer_pkg::*;

  localparam int unsigned N      = 8;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CH     = 2;
  localparam int unsigned FRAMES = 4;
  localparam int unsigned NVEC   = 22;

  typedef struct {
    int iv, ich, ist, isp, id, rr, rch;
    int ov, os, op, och, od, bsy, emp, drp, nck;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vt [NVEC];

  always #5 clock = ~clock;

  frame_buffer_if #(.N(N), .CH(CH)) bus ();

  frame_buffer_mc #(.N(N), .DEPTH(DEPTH), .CH(CH), .FRAMES(FRAMES)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic vec_t mkv(input int iv, ich, ist, isp, id, rr, rch,
                               input int ov, os, op, och, od, bsy, emp, drp, nck);
    vec_t r;
    r.iv = iv; r.ich = ich; r.ist = ist; r.isp = isp; r.id = id; r.rr = rr; r.rch = rch;
    r.ov = ov; r.os = os; r.op = op; r.och = och; r.od = od; r.bsy = bsy;
    r.emp = emp; r.drp = drp; r.nck = nck;
    return r;
  endfunction

  // Expected observable state; channel/data only matter on a valid word.
  function automatic logic [18:0] mk(input int ov, os, op, och, od, bsy, emp, ful, drp, nck);
    return {1'(ov), 1'(os), 1'(op), 1'((ov != 0) ? och : 0), 8'((ov != 0) ? od : 0),
            1'(bsy), 2'(emp), 2'(ful), 1'(drp), 1'(nck)};
  endfunction

  function automatic logic [18:0] snap();
    return {bus.out_valid, bus.out_start, bus.out_stop,
            bus.out_valid ? bus.out_ch : 1'b0, bus.out_valid ? bus.out_data : 8'h00,
            bus.busy, bus.empty, bus.full, bus.drop, bus.rd_nack};
  endfunction

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h", name, act, exp);
    end
  endtask

  task automatic drive(input int v, ch, st, sp, d, rr, rc);
    bus.in_valid = 1'(v);
    bus.in_ch    = 1'(ch);
    bus.in_start = 1'(st);
    bus.in_stop  = 1'(sp);
    bus.in_data  = 8'(d);
    bus.rd_req   = 1'(rr);
    bus.rd_ch    = 1'(rc);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // single frame on ch0 and its replay
    vt[0]  = mkv(1,0,1,0,'hA1,0,0, 0,0,0,0,0,0,    3,0,0);
    vt[1]  = mkv(1,0,0,0,'hA2,0,0, 0,0,0,0,0,0,    3,0,0);
    vt[2]  = mkv(1,0,0,1,'hA3,0,0, 0,0,0,0,0,0,    2,0,0);
    vt[3]  = mkv(0,0,0,0,0,1,0,    1,1,0,0,'hA1,1, 3,0,0);
    vt[4]  = mkv(0,0,0,0,0,0,0,    1,0,0,0,'hA2,1, 3,0,0);
    vt[5]  = mkv(0,0,0,0,0,0,0,    1,0,1,0,'hA3,1, 3,0,0);
    vt[6]  = mkv(0,0,0,0,0,0,0,    0,0,0,0,0,0,    3,0,0);
    // ch1 one-word frame, ch0 two-word frame, requests during SEND refused
    vt[7]  = mkv(1,1,1,1,'h55,0,0, 0,0,0,0,0,0,    1,0,0);
    vt[8]  = mkv(1,0,1,0,'h10,0,0, 0,0,0,0,0,0,    1,0,0);
    vt[9]  = mkv(1,0,0,1,'h11,0,0, 0,0,0,0,0,0,    0,0,0);
    vt[10] = mkv(0,0,0,0,0,1,1,    1,1,1,1,'h55,1, 2,0,0);
    vt[11] = mkv(0,0,0,0,0,1,0,    0,0,0,0,0,0,    2,0,1);
    vt[12] = mkv(0,0,0,0,0,1,0,    1,1,0,0,'h10,1, 3,0,0);
    vt[13] = mkv(0,0,0,0,0,1,0,    1,0,1,0,'h11,1, 3,0,1);
    vt[14] = mkv(0,0,0,0,0,0,0,    0,0,0,0,0,0,    3,0,0);
    // restart mid-frame discards the first attempt
    vt[15] = mkv(1,0,1,0,'h01,0,0, 0,0,0,0,0,0,    3,0,0);
    vt[16] = mkv(1,0,0,0,'h02,0,0, 0,0,0,0,0,0,    3,0,0);
    vt[17] = mkv(1,0,1,0,'h03,0,0, 0,0,0,0,0,0,    3,1,0);
    vt[18] = mkv(1,0,0,1,'h04,0,0, 0,0,0,0,0,0,    2,0,0);
    vt[19] = mkv(0,0,0,0,0,1,0,    1,1,0,0,'h03,1, 3,0,0);
    vt[20] = mkv(0,0,0,0,0,0,0,    1,0,1,0,'h04,1, 3,0,0);
    vt[21] = mkv(0,0,0,0,0,0,0,    0,0,0,0,0,0,    3,0,0);

    // reset held for 3 cycles under traffic
    idle();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, i % 2, 1, 1, 'h30 + i, 1, 0);
      step();
    end
    check("reset", snap(), mk(0,0,0,0,0,0,3,0,0,0));
    idle();
    reset_n = 1'b1;
    step();
    check("post_reset", snap(), mk(0,0,0,0,0,0,3,0,0,0));

    for (int i = 0; i < NVEC; i++) begin
      drive(vt[i].iv, vt[i].ich, vt[i].ist, vt[i].isp, vt[i].id, vt[i].rr, vt[i].rch);
      step();
      check($sformatf("vec%0d", i), snap(),
            mk(vt[i].ov, vt[i].os, vt[i].op, vt[i].och, vt[i].od, vt[i].bsy,
               vt[i].emp, 0, vt[i].drp, vt[i].nck));
    end

    // length queue full on ch1: fifth frame rejected
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 1, 1, 'h80 + i, 0, 0);
      step();
      check($sformatf("lenq_wr%0d", i), snap(), mk(0,0,0,0,0,0,1,0,(i == 4) ? 1 : 0,0));
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 1, 1);
      step();
      check($sformatf("lenq_rd%0d", i), snap(), mk(1,1,1,1,'h80 + i,1,(i == 3) ? 3 : 1,0,0,0));
      idle();
      step();
      check($sformatf("lenq_idle%0d", i), snap(), mk(0,0,0,0,0,0,(i == 3) ? 3 : 1,0,0,0));
    end
    drive(0, 0, 0, 0, 0, 1, 1);
    step();
    check("empty_nack", snap(), mk(0,0,0,0,0,0,3,0,0,1));

    // 9-word frame into 8 words of storage
    for (int k = 0; k < 9; k++) begin
      drive(1, 0, (k == 0) ? 1 : 0, (k == 8) ? 1 : 0, 'h20 + k, 0, 0);
      step();
      check($sformatf("ovf%0d", k), snap(),
            mk(0,0,0,0,0,0,3,(k == 7) ? 1 : 0,(k == 8) ? 1 : 0,0));
    end
    drive(1, 0, 0, 1, 'h77, 0, 0);
    step();
    check("ovf_orphan", snap(), mk(0,0,0,0,0,0,3,0,0,0));

    // pointer wrap: 20 five-word frames, each replayed immediately
    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < 5; k++) begin
        drive(1, 0, (k == 0) ? 1 : 0, (k == 4) ? 1 : 0, f * 5 + k, 0, 0);
        step();
      end
      check($sformatf("wrap_commit%0d", f), snap(), mk(0,0,0,0,0,0,2,0,0,0));
      for (int k = 0; k < 5; k++) begin
        if (k == 0) drive(0, 0, 0, 0, 0, 1, 0);
        else        idle();
        step();
        check($sformatf("wrap_f%0d_w%0d", f, k), snap(),
              mk(1,(k == 0) ? 1 : 0,(k == 4) ? 1 : 0,0,f * 5 + k,1,3,0,0,0));
      end
      idle();
      step();
      check($sformatf("wrap_end%0d", f), snap(), mk(0,0,0,0,0,0,3,0,0,0));
    end

    // reset during a replay leaves no trailing words
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, (k == 0) ? 1 : 0, (k == 2) ? 1 : 0, 'hC0 + k, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 1, 1);
    step();
    check("mid_replay_first", snap(), mk(1,1,0,1,'hC0,1,3,0,0,0));
    idle();
    reset_n = 1'b0;
    step();
    check("mid_replay_reset", snap(), mk(0,0,0,0,0,0,3,0,0,0));
    reset_n = 1'b1;
    step();
    check("mid_replay_after", snap(), mk(0,0,0,0,0,0,3,0,0,0));
    step();
    check("mid_replay_quiet", snap(), mk(0,0,0,0,0,0,3,0,0,0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
